// File: rtl/pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pattern_sequencer
//  Description : Multi-channel table-driven pattern sequencer with divider,
//                loop/one-shot modes, pause (en), abort (stop) and restart.
//  Revision    : 1.0 - initial release
// ============================================================================
module pattern_sequencer #(
    parameter int CH    = 2,
    parameter int DEPTH = 16,
    parameter int DIV   = 1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          start,
    input  logic          stop,
    input  logic          mode,
    input  logic [AW-1:0] len,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [CH-1:0] wr_data,
    output logic [CH-1:0] out,
    output logic [AW-1:0] step,
    output logic          busy,
    output logic          done
);

    localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] step_q, step_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [AW-1:0] len_q, len_d;
    logic          mode_q, mode_d;
    logic [CH-1:0] out_q, out_d;
    logic          done_q, done_d;
    logic [CH-1:0] mem_q [DEPTH];

    logic          w_wr_ok;
    logic [AW-1:0] w_len_clamped;

    // Address range checks only exist when the table does not fill the address space
    generate
        if (DEPTH == (1 << AW)) begin : g_pow2
            assign w_wr_ok       = wr_en;
            assign w_len_clamped = len;
        end else begin : g_npow2
            assign w_wr_ok       = wr_en && (wr_addr <= LAST_IDX);
            assign w_len_clamped = (len > LAST_IDX) ? LAST_IDX : len;
        end
    endgenerate

    function automatic logic [CH-1:0] entry(input logic [AW-1:0] a);
        entry = (w_wr_ok && (wr_addr == a)) ? wr_data : mem_q[a];
    endfunction

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        div_cnt_d = div_cnt_q;
        len_d     = len_q;
        mode_d    = mode_q;
        out_d     = out_q;
        done_d    = 1'b0;

        if (stop) begin
            state_d   = IDLE;
            step_d    = '0;
            div_cnt_d = '0;
            out_d     = '0;
        end else if (start) begin
            state_d   = RUN;
            step_d    = '0;
            div_cnt_d = '0;
            out_d     = entry('0);
            len_d     = w_len_clamped;
            mode_d    = mode;
        end else if ((state_q == RUN) && en) begin
            if (div_cnt_q != DIV_LAST) begin
                div_cnt_d = div_cnt_q + DW'(1);
            end else begin
                div_cnt_d = '0;
                if (step_q < len_q) begin
                    step_d = step_q + AW'(1);
                    out_d  = entry(step_q + AW'(1));
                end else if (!mode_q) begin
                    step_d = '0;
                    out_d  = entry('0);
                end else begin
                    state_d = IDLE;
                    step_d  = '0;
                    out_d   = '0;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            step_q    <= '0;
            div_cnt_q <= '0;
            len_q     <= '0;
            mode_q    <= 1'b0;
            out_q     <= '0;
            done_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            div_cnt_q <= div_cnt_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            out_q     <= out_d;
            done_q    <= done_d;
            if (w_wr_ok) begin
                mem_q[wr_addr] <= wr_data;
            end
        end
    end

    assign out  = out_q;
    assign step = step_q;
    assign busy = (state_q == RUN);
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pattern_sequencer
//  Description : Self-checking bench for pattern_sequencer; three instances
//                (DIV=1/DEPTH=16, DIV=3/DEPTH=16, DIV=1/DEPTH=12) share inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_sequencer;

    logic       clk = 1'b0;
    logic       reset, en, start, stop, mode, wr_en;
    logic [3:0] len, wr_addr;
    logic [1:0] wr_data;

    logic [1:0] out_s  [3];
    logic [3:0] step_s [3];
    logic       busy_s [3];
    logic       done_s [3];

    always #5 clk = ~clk;

    pattern_sequencer #(.CH(2), .DEPTH(16), .DIV(1)) u_a (
        .clk(clk), .reset(reset), .en(en), .start(start), .stop(stop), .mode(mode),
        .len(len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .out(out_s[0]), .step(step_s[0]), .busy(busy_s[0]), .done(done_s[0]));

    pattern_sequencer #(.CH(2), .DEPTH(16), .DIV(3)) u_b (
        .clk(clk), .reset(reset), .en(en), .start(start), .stop(stop), .mode(mode),
        .len(len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .out(out_s[1]), .step(step_s[1]), .busy(busy_s[1]), .done(done_s[1]));

    pattern_sequencer #(.CH(2), .DEPTH(12), .DIV(1)) u_c (
        .clk(clk), .reset(reset), .en(en), .start(start), .stop(stop), .mode(mode),
        .len(len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .out(out_s[2]), .step(step_s[2]), .busy(busy_s[2]), .done(done_s[2]));

    typedef struct {
        int         dut;
        logic [1:0] out;
        logic [3:0] step;
        logic       busy;
        logic       done;
    } exp_t;

    typedef struct {
        logic       en;
        logic       start;
        logic       stop;
        logic [1:0] out;
        logic [3:0] step;
        logic       busy;
        logic       done;
    } vec_t;

    exp_t sb[$];
    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [1:0] pat [11] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b01,
                             2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    logic [1:0] osh [3]  = '{2'b01, 2'b10, 2'b11};

    // Expectation is queued with the stimulus, then checked after the edge
    task automatic tick(input int d, input logic [1:0] eo, input logic [3:0] es,
                        input logic eb, input logic ed, input string nm);
        exp_t e;
        e.dut = d; e.out = eo; e.step = es; e.busy = eb; e.done = ed;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if ({out_s[e.dut], step_s[e.dut], busy_s[e.dut], done_s[e.dut]} !==
            {e.out, e.step, e.busy, e.done}) begin
            n_bad++;
            $display("FAIL %s dut%0d: got out=%b step=%0d busy=%b done=%b, want out=%b step=%0d busy=%b done=%b",
                     nm, e.dut, out_s[e.dut], step_s[e.dut], busy_s[e.dut], done_s[e.dut],
                     e.out, e.step, e.busy, e.done);
        end
    endtask

    function automatic vec_t mkv(input logic v_en, input logic v_start, input logic v_stop,
                                 input logic [1:0] v_out, input logic [3:0] v_step,
                                 input logic v_busy, input logic v_done);
        vec_t v;
        v.en = v_en; v.start = v_start; v.stop = v_stop;
        v.out = v_out; v.step = v_step; v.busy = v_busy; v.done = v_done;
        return v;
    endfunction

    initial begin
        logic [3:0] s;

        // Basic loop with pause, abort, and start+stop in idle
        vq.push_back(mkv(1'b1, 1'b1, 1'b0, pat[0], 4'd0, 1'b1, 1'b0));
        for (int k = 1; k <= 26; k++) begin
            vq.push_back(mkv(1'b1, 1'b0, 1'b0, pat[k % 11], 4'(k % 11), 1'b1, 1'b0));
        end
        for (int k = 0; k < 5; k++) begin
            vq.push_back(mkv(1'b0, 1'b0, 1'b0, pat[4], 4'd4, 1'b1, 1'b0));
        end
        vq.push_back(mkv(1'b1, 1'b0, 1'b0, pat[5], 4'd5, 1'b1, 1'b0));
        vq.push_back(mkv(1'b1, 1'b0, 1'b0, pat[6], 4'd6, 1'b1, 1'b0));
        vq.push_back(mkv(1'b1, 1'b0, 1'b1, 2'b00, 4'd0, 1'b0, 1'b0));
        vq.push_back(mkv(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0));
        vq.push_back(mkv(1'b1, 1'b1, 1'b1, 2'b00, 4'd0, 1'b0, 1'b0));
        vq.push_back(mkv(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0));

        reset = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
        len = 4'd0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 2'b00;

        for (int d = 0; d < 3; d++) begin
            tick(d, 2'b00, 4'd0, 1'b0, 1'b0, "reset");
        end
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = pat[i];
            tick(0, 2'b00, 4'd0, 1'b0, 1'b0, "load_idle");
        end
        wr_en = 1'b0;

        len = 4'd10; mode = 1'b0;
        for (int i = 0; i < vq.size(); i++) begin
            en = vq[i].en; start = vq[i].start; stop = vq[i].stop;
            tick(0, vq[i].out, vq[i].step, vq[i].busy, vq[i].done, "loop_vec");
        end
        start = 1'b0; stop = 1'b0; en = 1'b1;

        // Restart mid-run with shorter length, then forwarding at the wrap
        start = 1'b1;
        tick(0, pat[0], 4'd0, 1'b1, 1'b0, "run_start");
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick(0, pat[k], 4'(k), 1'b1, 1'b0, "run_to_7");
        end
        len = 4'd3; start = 1'b1;
        tick(0, pat[0], 4'd0, 1'b1, 1'b0, "restart");
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick(0, pat[k], 4'(k), 1'b1, 1'b0, "restart_run");
        end
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 2'b11;
        tick(0, 2'b11, 4'd0, 1'b1, 1'b0, "fwd_wrap");
        wr_en = 1'b0;
        tick(0, pat[1], 4'd1, 1'b1, 1'b0, "after_fwd");
        stop = 1'b1;
        tick(0, 2'b00, 4'd0, 1'b0, 1'b0, "stop");
        stop = 1'b0;

        // One-shot on the DIV=3 instance
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = osh[i];
            tick(1, 2'b00, 4'd0, 1'b0, 1'b0, "load_osh");
        end
        wr_en = 1'b0;
        len = 4'd2; mode = 1'b1; start = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick(1, osh[k / 3], 4'(k / 3), 1'b1, 1'b0, "oneshot_run");
            start = 1'b0;
        end
        tick(1, 2'b00, 4'd0, 1'b0, 1'b1, "oneshot_done");
        tick(1, 2'b00, 4'd0, 1'b0, 1'b0, "oneshot_after");

        // Clamping and out-of-range writes on the DEPTH=12 instance
        for (int i = 0; i < 16; i++) begin
            s = 4'(i);
            wr_en = 1'b1; wr_addr = s; wr_data = (i < 12) ? s[1:0] : 2'b11;
            tick(2, 2'b00, 4'd0, 1'b0, 1'b0, "load_clamp");
        end
        wr_en = 1'b0;
        len = 4'd15; mode = 1'b0; start = 1'b1;
        for (int k = 0; k < 14; k++) begin
            s = 4'(k % 12);
            tick(2, s[1:0], s, 1'b1, 1'b0, "clamp_run");
            start = 1'b0;
        end
        stop = 1'b1;
        tick(2, 2'b00, 4'd0, 1'b0, 1'b0, "clamp_stop");
        stop = 1'b0;

        // Mid-run reset erases the table
        len = 4'd10; start = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            s = 4'(k);
            tick(0, s[1:0], s, 1'b1, 1'b0, "pre_reset");
            start = 1'b0;
        end
        reset = 1'b1;
        tick(0, 2'b00, 4'd0, 1'b0, 1'b0, "reset_mid");
        reset = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 13; k++) begin
            tick(0, 2'b00, 4'(k % 11), 1'b1, 1'b0, "post_reset");
            start = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
